uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate in bit/s.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 rx  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-006 rx_data  output  8  last correctly framed byte; held until the next good frame.
REQ-007 rx_done  output  1  one-clock pulse marking a new valid rx_data; directly drives the command decoder's rx_done.
REQ-008 rx_busy  output  1  high while a frame is in progress, i.e. in any state other than IDLE.
REQ-009 frame_err  output  1  one-clock pulse when the stop bit samples low.

Function
REQ-010 rx SHALL pass a 2-flop synchronizer (reset value 1); all logic below SHALL use the synchronized value rx_s.
REQ-011 A free-running tick generator SHALL pulse tick for one clock every DIV = CLK_FREQ/(BAUD*16) clocks (integer division), counting 0..DIV-1 and wrapping to 0.
REQ-012 The FSM SHALL have exactly four states: IDLE, START, DATA and STOP; its encoding is free.
REQ-013 IDLE: a falling edge on rx_s (previous 1, current 0) SHALL enter START and clear the tick count; a line held low without an edge SHALL NOT start a frame.
REQ-014 START: on the 8th tick (mid start bit), if rx_s=0 the FSM SHALL enter DATA and clear the tick count and bit index; if rx_s=1 it SHALL return to IDLE (glitch reject) with no output pulse.
REQ-015 DATA: on every 16th tick (mid bit) the sampled bit SHALL shift in LSB-first and the bit index SHALL increment; after bit 7 the FSM SHALL enter STOP.
REQ-016 STOP: on the 16th tick, if the sample is 1, the FSM SHALL load rx_data with the shift register and pulse rx_done in the same clock; if the sample is 0, it SHALL pulse frame_err and leave rx_data unchanged.
REQ-017 After STOP the FSM SHALL go to IDLE; a new frame SHALL require a fresh falling edge, so a break (line held low) yields exactly one frame_err.
REQ-018 rx_done and frame_err SHALL never be high together, and each SHALL be high for exactly one clock per frame.
REQ-019 Latency: rx_done SHALL rise within 9.5 bit times plus 3 clocks + DIV clocks of the start-bit falling edge on rx.
REQ-020 A falling edge on rx during DATA or STOP SHALL be ignored; it SHALL NOT restart the frame.

Reset
REQ-021 While rst=0: FSM=IDLE, rx_data=8'h00, rx_done=0, rx_busy=0, frame_err=0, synchronizer=1, tick, sample and bit counters=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no rx_done and no frame_err pulse; after release the FSM SHALL wait in IDLE for a new falling edge.

Configuration
REQ-023 Macro UART_RX_MAJORITY_EN defined: each data and stop bit SHALL be the 2-of-3 majority of rx_s sampled at ticks 7, 8 and 9 of the bit, and the START check SHALL use the majority of ticks 6, 7 and 8.
REQ-024 UART_RX_MAJORITY_EN undefined: each bit SHALL be a single rx_s sample at the tick given in REQ-014/REQ-015; no vote logic SHALL be synthesized.

Verification (bench: CLK_FREQ=6_400_000, BAUD=100_000 -> DIV=4, 64 clk/bit)
REQ-025 Send 0x55 ('U') 8N1 -> one rx_done pulse, rx_data=8'h55, frame_err=0, rx_busy high for the whole frame.
REQ-026 Send 0x72, 0x1B, 0x4D back-to-back with 1 stop bit each -> three rx_done pulses carrying 8'h72, 8'h1B and 8'h4D in order.
REQ-027 Send 0xA5 with the stop bit forced low, then hold rx high -> frame_err pulses once, no rx_done, rx_data keeps its previous value.
REQ-028 Drive rx low for 20 clocks, then high -> no rx_done, no frame_err, rx_busy returns to 0 within 40 clocks.
REQ-029 Assert rst during bit 4 of 0x3C, release, then send 0x44 -> no pulse for 0x3C; rx_done with 8'h44.
REQ-030 With UART_RX_MAJORITY_EN defined, inject a 1-tick inverted glitch at tick 8 of each data bit of 0x4E -> rx_data=8'h4E; undefined, same stimulus -> rx_data differs from 8'h4E.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, 16x oversampling from a free-running tick.
// Optional feature: define UART_RX_MAJORITY_EN to take each start/data/stop
// decision as a 2-of-3 vote over three consecutive ticks around mid-bit.
// Without the macro every bit is a single mid-bit sample and no vote
// hardware exists.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // Start is judged on the 8th tick after the falling edge.
  localparam logic [4:0] START_LAST = 5'd7;
`ifdef UART_RX_MAJORITY_EN
  // The vote needs the tick after mid-bit, so the first data decision lands
  // on the 17th tick; reloading with 1 keeps later decisions 16 ticks apart.
  localparam logic [4:0] BIT_LAST   = 5'd16;
  localparam logic [4:0] BIT_RELOAD = 5'd1;
`else
  localparam logic [4:0] BIT_LAST   = 5'd15;
  localparam logic [4:0] BIT_RELOAD = 5'd0;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  state_t           state_q, state_d;
  logic [4:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             bit_val;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Free-running 16x-baud tick divider.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_cnt_q <= '0;
    else      div_cnt_q <= div_cnt_d;
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q, vote_d;
  logic [4:0] vote_last;

  // Capture the two samples preceding each decision tick.
  always_comb begin
    vote_d    = vote_q;
    vote_last = (state_q == START) ? START_LAST : BIT_LAST;
    if (tick && (state_q != IDLE)) begin
      if (tick_cnt_q == vote_last - 5'd2) vote_d[0] = rx_s_q;
      if (tick_cnt_q == vote_last - 5'd1) vote_d[1] = rx_s_q;
    end
    bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
  end

  // Vote sample register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vote_q <= 2'b00;
    else      vote_q <= vote_d;
  end
`else
  // Single mid-bit sample.
  always_comb bit_val = rx_s_q;
`endif

  // Receive FSM next-state and datapath.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == START_LAST) begin
            if (!bit_val) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            shift_d    = {bit_val, shift_q[7:1]};
            tick_cnt_d = BIT_RELOAD;
            bit_idx_d  = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            if (bit_val) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames, a monitor
// pops and compares on every rx_done / frame_err pulse.
module tb_uart_rx;

  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CLKS = DIV * 16;
  localparam int LAT_MAX  = (BIT_CLKS * 19) / 2 + 3 + DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned start_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pop one expected frame per output pulse.
  always @(negedge clk) begin
    if (rst && (rx_done || frame_err)) begin
      if (rx_done && frame_err) begin
        check("done_err_together", 1, 0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, rx_done, frame_err}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("rx %s data=0x%02h expect %s 0x%02h latency=%0d",
                 rx_done ? "DONE" : "FERR", rx_data, e.is_err ? "FERR" : "DONE",
                 e.data, cyc - e.start_cyc);
        check("pulse_kind_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        if (rx_done) begin
          n_cmp++;
          if (cyc - e.start_cyc > LAT_MAX) begin
            n_bad++;
            $display("FAIL latency: got %0d clocks, required <= %0d", cyc - e.start_cyc, LAT_MAX);
          end
        end
      end
    end
  end

  // Send one frame starting at the current negedge; ends at a negedge with rx
  // left at the stop-bit level. exp_d is the rx_data the model predicts.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit glitch,
                            input bit chk_busy, input logic [7:0] exp_d);
    exp_t e;
    rx          = 1'b0;
    e.start_cyc = cyc;
    e.is_err    = !stop_ok;
    if (stop_ok) last_good = exp_d;
    e.data      = last_good;
    exp_q.push_back(e);
    repeat (BIT_CLKS / 2) @(negedge clk);
    if (chk_busy) check("busy_start_bit", {31'd0, rx_busy}, 1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (glitch) begin
        // Invert rx for exactly one tick around the mid-bit sample point.
        repeat (29) @(negedge clk);
        rx = ~d[i];
        repeat (DIV) @(negedge clk);
        rx = d[i];
        repeat (BIT_CLKS - 29 - DIV) @(negedge clk);
      end else begin
        repeat (BIT_CLKS / 2) @(negedge clk);
        if (chk_busy) check("busy_data_bit", {31'd0, rx_busy}, 1);
        repeat (BIT_CLKS / 2) @(negedge clk);
      end
    end
    rx = stop_ok;
    repeat (BIT_CLKS / 4) @(negedge clk);
    if (chk_busy) check("busy_stop_bit", {31'd0, rx_busy}, 1);
    repeat (BIT_CLKS - BIT_CLKS / 4) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},   {24'd0, rx_data}, 0);
    check({tag, "_rx_done"},   {31'd0, rx_done}, 0);
    check({tag, "_rx_busy"},   {31'd0, rx_busy}, 0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] glitch_exp;
    bit         ok;
    int         gap;
    int         waited;

    last_good = 8'h00;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(20);
    check("busy_idle", {31'd0, rx_busy}, 0);

    // Single 'U' with busy checked through the frame.
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 8'h55);
    idle(40);
    check("busy_after_U", {31'd0, rx_busy}, 0);

    // Back-to-back frames.
    send_frame(8'h72, 1'b1, 1'b0, 1'b0, 8'h72);
    send_frame(8'h1B, 1'b1, 1'b0, 1'b0, 8'h1B);
    send_frame(8'h4D, 1'b1, 1'b0, 1'b0, 8'h4D);
    idle(100);

    // Bad stop bit: frame_err, rx_data keeps 0x4D.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(100);
    check("rx_data_kept_after_ferr", {24'd0, rx_data}, 32'h4D);

    // Break: stop low then line held low; exactly one frame_err.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (BIT_CLKS * 11) @(negedge clk);
    check("busy_during_break", {31'd0, rx_busy}, 0);
    idle(100);

    // Short low glitch: rejected in START.
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_in_glitch", {31'd0, rx_busy}, 1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("busy_after_glitch", {31'd0, rx_busy}, 0);
    idle(40);

    // Reset during bit 4 of 0x3C, then 0x44.
    d = 8'h3C;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midframe_reset");
    last_good = 8'h00;
    rst = 1'b1;
    idle(BIT_CLKS * 11);
    send_frame(8'h44, 1'b1, 1'b0, 1'b0, 8'h44);
    idle(100);

    // One-tick glitch at mid-bit of every data bit.
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h4E;
`else
    glitch_exp = 8'hB1;
`endif
    send_frame(8'h4E, 1'b1, 1'b1, 1'b0, glitch_exp);
    idle(100);

    // Randomized frames with occasional bad stop bits and random gaps.
    for (int n = 0; n < 16; n++) begin
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 20);
      if (!ok && gap < 2) gap = 2;
      send_frame(d, ok, 1'b0, 1'b0, d);
      idle(gap);
    end

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    idle(BIT_CLKS * 2);
    check("pending_expected", exp_q.size(), 0);
    check("busy_final", {31'd0, rx_busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
